// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master bus arbiter running setup / wait / ack transactions on a shared bus.
// Define ARBITER_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise master 0 wins ties.
module bus_arbiter #(
    parameter int ADDR_WIDTH  = 19,
    parameter int DATA_WIDTH  = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic                  m0_write,
    input  logic [ADDR_WIDTH-1:0] m0_address,
    input  logic [DATA_WIDTH-1:0] m0_data_in,
    output logic [DATA_WIDTH-1:0] m0_data_out,
    output logic                  m0_ack,
    input  logic                  m1_req,
    input  logic                  m1_write,
    input  logic [ADDR_WIDTH-1:0] m1_address,
    input  logic [DATA_WIDTH-1:0] m1_data_in,
    output logic [DATA_WIDTH-1:0] m1_data_out,
    output logic                  m1_ack,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_write_en,
    output logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    output logic [1:0]            owner
);
    typedef enum logic [1:0] {IDLE, SETUP, WAIT, ACK} state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    state_t                  state;
    state_t                  state_next;
    logic [3:0]              count;
    logic                    lat_write;
    logic [ADDR_WIDTH-1:0]   lat_address;
    logic [DATA_WIDTH-1:0]   lat_data;
    logic                    any_req;
    logic                    pick_m1;
    logic                    ack_entry;

    assign any_req   = m0_req | m1_req;
    assign ack_entry = (state_next == ACK);

`ifdef ARBITER_ROUND_ROBIN_EN
    logic last_m1;
    // On a tie, serve whichever master was not acked last.
    assign pick_m1 = (m0_req & m1_req) ? ~last_m1 : m1_req;
`else
    assign pick_m1 = m1_req & ~m0_req;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = (state == IDLE)  ? (any_req ? SETUP : IDLE) :
                     (state == SETUP) ? ((WAIT_STATES == 0) ? ACK : WAIT) :
                     (state == WAIT)  ? ((count == 4'd0) ? ACK : WAIT) :
                                        IDLE;
    end

    always_comb begin
        mem_address  = lat_address;
        mem_data_out = lat_data;
        mem_write_en = (state == SETUP) && lat_write;
        m0_ack       = (state == ACK) && (owner == 2'b01);
        m1_ack       = (state == ACK) && (owner == 2'b10);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count       <= 4'd0;
            lat_write   <= 1'b0;
            lat_address <= '0;
            lat_data    <= '0;
            owner       <= 2'b00;
            m0_data_out <= '0;
            m1_data_out <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                lat_write   <= pick_m1 ? m1_write   : m0_write;
                lat_address <= pick_m1 ? m1_address : m0_address;
                lat_data    <= pick_m1 ? m1_data_in : m0_data_in;
                owner       <= pick_m1 ? 2'b10 : 2'b01;
            end
            if (state == ACK)
                owner <= 2'b00;
            if (state == SETUP)
                count <= WAIT_LOAD;
            else if (state == WAIT && count != 4'd0)
                count <= count - 4'd1;
            // Read data is taken from the bus on the edge that enters ACK.
            if (ack_entry && !lat_write && owner == 2'b01)
                m0_data_out <= mem_data_in;
            if (ack_entry && !lat_write && owner == 2'b10)
                m1_data_out <= mem_data_in;
        end
    end

`ifdef ARBITER_ROUND_ROBIN_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            last_m1 <= 1'b1;
        else if (ack_entry)
            last_m1 <= owner[1];
    end
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: drives three arbiters (WAIT_STATES 0, 1, 15) with shared stimulus against a transaction-level model.
module tb_bus_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        m0_req = 1'b0, m0_write = 1'b0, m1_req = 1'b0, m1_write = 1'b0;
    logic [18:0] m0_address = '0, m1_address = '0;
    logic [7:0]  m0_data_in = '0, m1_data_in = '0, mem_data_in = '0;

    logic [7:0]  d0 [3];
    logic [7:0]  d1 [3];
    logic        a0 [3];
    logic        a1 [3];
    logic [18:0] ma [3];
    logic        we [3];
    logic [7:0]  mdo [3];
    logic [1:0]  own [3];

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : gd
        bus_arbiter #(.ADDR_WIDTH(19), .DATA_WIDTH(8), .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 1 : 15))) dut (
            .clock(clock), .reset(reset),
            .m0_req(m0_req), .m0_write(m0_write), .m0_address(m0_address), .m0_data_in(m0_data_in),
            .m0_data_out(d0[g]), .m0_ack(a0[g]),
            .m1_req(m1_req), .m1_write(m1_write), .m1_address(m1_address), .m1_data_in(m1_data_in),
            .m1_data_out(d1[g]), .m1_ack(a1[g]),
            .mem_address(ma[g]), .mem_write_en(we[g]), .mem_data_out(mdo[g]), .mem_data_in(mem_data_in),
            .owner(own[g])
        );
    end

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int ws_v [3] = '{0, 1, 15};

    // Model: a transaction started at a sampling edge is in cycle t after it; t=1 setup, t=ws+2 ack.
    logic        busy [3];
    int          t [3];
    logic        w [3];
    logic        wr [3];
    logic [18:0] ad [3];
    logic [7:0]  da [3];
    logic [7:0]  e0 [3];
    logic [7:0]  e1 [3];
    logic        last [3];

    int n_we [3];
    int n_a0 [3];
    int n_a1 [3];
    int ack_at [3];
    logic [1:0] own_we [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            busy[k] = 1'b0; t[k] = 0; w[k] = 1'b0; wr[k] = 1'b0;
            ad[k] = '0; da[k] = '0; e0[k] = '0; e1[k] = '0; last[k] = 1'b1;
        end
    endtask

    task automatic clr();
        for (int k = 0; k < 3; k++) begin
            n_we[k] = 0; n_a0[k] = 0; n_a1[k] = 0; ack_at[k] = -1; own_we[k] = 2'b00;
        end
    endtask

    task automatic sample();
        for (int k = 0; k < 3; k++) begin
            logic ack_now;
            ack_now = busy[k] && t[k] == ws_v[k] + 2;
            check($sformatf("owner%0d", k), 32'(own[k]), busy[k] ? (w[k] ? 32'd2 : 32'd1) : 32'd0);
            check($sformatf("we%0d", k), 32'(we[k]), 32'(busy[k] && t[k] == 1 && wr[k]));
            check($sformatf("ack0_%0d", k), 32'(a0[k]), 32'(ack_now && !w[k]));
            check($sformatf("ack1_%0d", k), 32'(a1[k]), 32'(ack_now && w[k]));
            check($sformatf("addr%0d", k), 32'(ma[k]), 32'(ad[k]));
            check($sformatf("wdata%0d", k), 32'(mdo[k]), 32'(da[k]));
            check($sformatf("rd0_%0d", k), 32'(d0[k]), 32'(e0[k]));
            check($sformatf("rd1_%0d", k), 32'(d1[k]), 32'(e1[k]));
            if (we[k]) begin n_we[k]++; own_we[k] = own[k]; end
            if (a0[k]) begin n_a0[k]++; ack_at[k] = cyc; end
            if (a1[k]) begin n_a1[k]++; ack_at[k] = cyc; end
        end
    endtask

    task automatic step();
        for (int k = 0; k < 3; k++) begin
            if (!busy[k]) begin
                if (m0_req || m1_req) begin
                    logic p;
`ifdef ARBITER_ROUND_ROBIN_EN
                    p = (m0_req && m1_req) ? !last[k] : m1_req;
`else
                    p = !m0_req;
`endif
                    w[k]  = p;
                    wr[k] = p ? m1_write : m0_write;
                    ad[k] = p ? m1_address : m0_address;
                    da[k] = p ? m1_data_in : m0_data_in;
                    busy[k] = 1'b1;
                    t[k] = 1;
                end
            end else if (t[k] == ws_v[k] + 2) begin
                busy[k] = 1'b0;
            end else begin
                if (t[k] == ws_v[k] + 1) begin
                    if (!wr[k]) begin
                        if (w[k]) e1[k] = mem_data_in;
                        else e0[k] = mem_data_in;
                    end
                    last[k] = w[k];
                end
                t[k]++;
            end
        end
    endtask

    task automatic cycle();
        #1 sample();
        step();
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    // Async reset asserted mid-cycle, well away from any clock edge.
    task automatic rst_cycle();
        #1 sample();
        #2 reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_owner%0d", k), 32'(own[k]), 32'd0);
            check($sformatf("rst_we%0d", k), 32'(we[k]), 32'd0);
            check($sformatf("rst_ack%0d", k), 32'({a0[k], a1[k]}), 32'd0);
            check($sformatf("rst_addr%0d", k), 32'(ma[k]), 32'd0);
            check($sformatf("rst_wdata%0d", k), 32'(mdo[k]), 32'd0);
            check($sformatf("rst_rd%0d", k), 32'({d0[k], d1[k]}), 32'd0);
        end
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        cyc++;
    endtask

    initial begin
        int c0;
        model_reset();
        clr();
        @(negedge clock);
        #1;
        for (int k = 0; k < 3; k++)
            check($sformatf("init%0d", k), 32'({own[k], we[k], a0[k], a1[k], ma[k]}), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        cycle();

        // m0 read with fixed bus data
        clr();
        m0_req = 1'b1; m0_write = 1'b0; m0_address = 19'h0FF10; mem_data_in = 8'h5A;
        c0 = cyc;
        cycle();
        m0_req = 1'b0;
        repeat (20) cycle();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rd_val%0d", k), 32'(d0[k]), 32'h5A);
            check($sformatf("rd_lat%0d", k), 32'(ack_at[k] - c0), 32'(2 + ws_v[k]));
            check($sformatf("rd_nowe%0d", k), 32'(n_we[k]), 32'd0);
            check($sformatf("rd_addr%0d", k), 32'(ma[k]), 32'h0FF10);
        end

        // m1 write
        clr();
        m1_req = 1'b1; m1_write = 1'b1; m1_address = 19'h0FF20; m1_data_in = 8'hC3;
        cycle();
        m1_req = 1'b0;
        repeat (20) cycle();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("wr_we%0d", k), 32'(n_we[k]), 32'd1);
            check($sformatf("wr_own%0d", k), 32'(own_we[k]), 32'd2);
            check($sformatf("wr_acks%0d", k), 32'({n_a0[k][7:0], n_a1[k][7:0]}), 32'h0001);
            check($sformatf("wr_bus%0d", k), 32'({ma[k], mdo[k]}), 32'({19'h0FF20, 8'hC3}));
        end

        // Simultaneous held requests
        clr();
        m0_req = 1'b1; m1_req = 1'b1; m0_write = 1'b0; m1_write = 1'b0;
        repeat (60) begin mem_data_in = 8'($urandom); cycle(); end
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (20) cycle();
        for (int k = 0; k < 3; k++) begin
`ifdef ARBITER_ROUND_ROBIN_EN
            check($sformatf("rr_alt%0d", k), 32'(n_a0[k] - n_a1[k] == 0 || n_a0[k] - n_a1[k] == 1), 32'd1);
            check($sformatf("rr_m1%0d", k), 32'(n_a1[k] > 0), 32'd1);
`else
            check($sformatf("fp_m1%0d", k), 32'(n_a1[k]), 32'd0);
            check($sformatf("fp_m0%0d", k), 32'(n_a0[k] > 2), 32'd1);
`endif
        end

        // Request dropped and address changed mid-transaction, m1 waiting
        clr();
        m0_req = 1'b1; m0_address = 19'h0FF30; mem_data_in = 8'h3C;
        cycle();
        m0_req = 1'b0; m0_address = 19'h00001; m1_req = 1'b1; m1_address = 19'h0FF40;
        cycle();
        for (int k = 0; k < 3; k++)
            check($sformatf("mid_addr%0d", k), 32'(ma[k]), 32'h0FF30);
        repeat (18) cycle();
        m1_req = 1'b0;
        repeat (20) cycle();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("mid_ack0_%0d", k), 32'(n_a0[k]), 32'd1);
            check($sformatf("mid_ack1_%0d", k), 32'(n_a1[k] > 0), 32'd1);
        end

        // Reset during the SETUP of a write
        clr();
        m1_req = 1'b1; m1_write = 1'b1; m1_address = 19'h0FF50; m1_data_in = 8'h77;
        cycle();
        m1_req = 1'b0;
        rst_cycle();
        repeat (20) cycle();
        for (int k = 0; k < 3; k++)
            check($sformatf("abort%0d", k), 32'({n_we[k][7:0], n_a1[k][7:0]}), 32'h0100);
        clr();
        m0_req = 1'b1; m0_write = 1'b0; m0_address = 19'h00123; mem_data_in = 8'hE1;
        cycle();
        m0_req = 1'b0;
        repeat (20) cycle();
        for (int k = 0; k < 3; k++)
            check($sformatf("post_rst%0d", k), 32'({n_a0[k][7:0], d0[k]}), 32'h01E1);

        // Randomized traffic with occasional async reset
        repeat (3000) begin
            m0_req = $urandom_range(0, 99) < 45;
            m1_req = $urandom_range(0, 99) < 45;
            m0_write = 1'($urandom);
            m1_write = 1'($urandom);
            m0_address = 19'($urandom);
            m1_address = 19'($urandom);
            m0_data_in = 8'($urandom);
            m1_data_in = 8'($urandom);
            mem_data_in = 8'($urandom);
            if ($urandom_range(0, 299) == 0) rst_cycle();
            else cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
